inst_pipe_fifo: RTL and testbench
=================================

Name: inst_pipe_fifo

Overview:
Parametrised elastic pipeline stage between decode and execute. It replaces the fixed single-register instruction buffer with a DEPTH-entry FIFO. The FIFO carries one packed decoded-instruction word of DATA_W bits and uses a valid/ready handshake. It also supports flush on branch/PC redirect and inserts all-zero (NOP) bubbles when empty.

Parameters:
- DATA_W, 79, width of the packed decoded-instruction word (alu 8, pc 2, reg 2, imm 1, mem 1, 4x reg addr 5, ram addr 16, 2x imm data 8, npu ram addr 8, npu w reg addr 5).
- DEPTH, 2, number of entries; legal range 1..16, not required to be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  decode presents a word.
- in_data_i  in  DATA_W  packed decoded word.
- in_ready_o  out  1  buffer can accept a word.
- out_valid_o  out  1  head entry valid.
- out_data_o  out  DATA_W  head entry; all-zero when empty.
- out_ready_i  in  1  execute consumes the head.
- flush_i  in  1  discard all entries (branch/redirect).
- count_o  out  CNT_W  current occupancy.
- stall_cnt_o  out  16  backpressure cycle counter (see Optional Feature).

Behaviour:
- Single clock domain, clk_i. Reset is asynchronous and active-high.
- Reset values: rd_ptr=0, wr_ptr=0, count_o=0, out_valid_o=0, out_data_o=0, stall_cnt_o=0. Storage contents are don't-care.
- Reset mid-operation: all entries are lost immediately. No handshake completes in the reset cycle.
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i.
- in_ready_o = (count_o != DEPTH). It is combinational from state only, with no dependence on out_ready_i. A full FIFO therefore rejects a push even when a pop happens in the same cycle.
- out_valid_o = (count_o != 0). out_data_o = mem[rd_ptr] when valid, else all-zero (NOP bubble).
- Latency: a word pushed at edge N appears on out_data_o after edge N. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Count update per edge: push only: +1. Pop only: -1. Push and pop together: unchanged, and both pointers advance.
- Pointer wrap: a pointer at DEPTH-1 goes to 0 when it advances. Non-power-of-two DEPTH must work.
- Empty with in_valid_i=1: the word is accepted. Output stays zero/invalid that cycle and becomes valid the next cycle.
- Full with out_ready_i=0: in_ready_o=0 and contents are held unchanged.
- Flush: when flush_i=1 at an edge, rd_ptr, wr_ptr and count go to 0.
  - Any same-cycle push is discarded.
  - Any same-cycle pop is still considered consumed by the downstream stage; the FIFO simply ends empty.
  - Flush has priority over push and pop.
  - The cycle after a flush: out_valid_o=0, out_data_o=0, in_ready_o=1.
- Flush while empty: no effect.
- Data integrity: words leave in the order accepted, bit-exact, with no duplication or loss except by flush or reset.

Optional Feature:
- Macro: INST_BUF_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments on each edge where out_valid_o=1 and out_ready_i=0.
  - It saturates at 16'hFFFF and is cleared only by rst_i; flush does not clear it.
- Undefined: stall_cnt_o is tied to 16'h0000 and no counter logic is instantiated.

Test Plan:
- Reset, then idle -> out_valid_o=0, out_data_o=0, count_o=0, in_ready_o=1. Assert rst_i asynchronously mid-run with count=2 -> all outputs return to reset values before the next edge.
- Push 0x1A, 0x2B back-to-back with out_ready_i=0 (DEPTH=2) -> count_o=2, in_ready_o=0. A third word 0x3C is held off. Release out_ready_i -> outputs 0x1A, 0x2B, then 0x3C, in order.
- Continuous streaming, in_valid_i=1 and out_ready_i=1, 100 incrementing words -> after a 1-cycle fill, one word per cycle; count_o stays at 1; output sequence equals input.
- Full FIFO holding 0x11, 0x22, flush_i=1 with a simultaneous push of 0x33 -> next cycle count_o=0, out_valid_o=0, out_data_o=0. 0x33 never appears at the output.
- DEPTH=3 build, 10 pushes with random out_ready_i -> pointers wrap 2->0 correctly; no loss, duplication or reordering.
- With INST_BUF_STALL_CNT_EN, hold out_ready_i=0 for 5 cycles with count_o=1 -> stall_cnt_o=5; flush leaves it at 5. Without the macro -> stall_cnt_o stays 0.

Source files
------------

// File: rtl/inst_pipe_fifo.sv
// -----------------------------------------------------------------------------
// inst_pipe_fifo
//
// Elastic pipeline stage between decode and execute. Holds up to DEPTH packed
// decoded-instruction words in a circular buffer with a valid/ready handshake
// on both sides. A flush (branch / PC redirect) empties the buffer in one
// cycle. When the buffer is empty the output word is forced to all-zero so
// execute sees a NOP bubble.
//
// Optional feature (compile-time macro INST_BUF_STALL_CNT_EN):
//   defined   -> stall_cnt_o counts cycles where the head is valid but execute
//                is not ready; saturates at 16'hFFFF, cleared only by reset.
//   undefined -> stall_cnt_o is tied to zero and no counter exists.
//
// Parameters:
//   DATA_W  width of the packed decoded-instruction word
//   DEPTH   number of entries (1..16, any value, not only powers of two)
//   CNT_W   width of the occupancy count
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous active-high reset
//   in_valid_i   in   decode presents a word
//   in_data_i    in   packed decoded word
//   in_ready_o   out  buffer can accept a word (state-only, no pop look-ahead)
//   out_valid_o  out  head entry valid
//   out_data_o   out  head entry, all-zero when empty
//   out_ready_i  in   execute consumes the head
//   flush_i      in   discard all entries
//   count_o      out  current occupancy
//   stall_cnt_o  out  backpressure cycle counter
// -----------------------------------------------------------------------------
module inst_pipe_fifo #(
  parameter int DATA_W = 79,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [15:0]       stall_cnt_o
);

  // A single-entry buffer still needs a 1-bit pointer to be a legal vector.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends on occupancy only: a full buffer refuses a push even if the
  // head is popped in the same cycle, which keeps in_ready_o off the
  // out_ready_i timing path.
  assign in_ready_o  = !w_full;
  assign out_valid_o = !w_empty;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  assign out_data_o = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign count_o    = r_count;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      // Flush wins over push and pop; a same-cycle pop is still taken by
      // execute, the buffer just ends empty.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only observable through
  // out_data_o when count says they are valid, so clearing them costs
  // area and buys nothing.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= in_data_i;
    end
  end

`ifdef INST_BUF_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts head-blocked cycles; flush deliberately leaves it alone so the
  // statistic survives redirects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_inst_pipe_fifo.sv
// -----------------------------------------------------------------------------
// tb_inst_pipe_fifo
//
// Directed bench for inst_pipe_fifo. A DEPTH=2 instance is driven from a
// vector table plus hand-written sequences (async reset, stall counter,
// streaming); a DEPTH=3 instance checks pointer wrap with a queue model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_inst_pipe_fifo;

  localparam int DATA_W = 79;

`ifdef INST_BUF_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd5;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic              clk;
  logic              rst;

  // DEPTH=2 instance
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [1:0]        count;
  logic [15:0]       stall_cnt;

  // DEPTH=3 instance
  logic              in_valid3;
  logic [DATA_W-1:0] in_data3;
  logic              in_ready3;
  logic              out_valid3;
  logic [DATA_W-1:0] out_data3;
  logic              out_ready3;
  logic              flush3;
  logic [1:0]        count3;
  logic [15:0]       stall_cnt3;

  int n_checks = 0;
  int n_errors = 0;

  inst_pipe_fifo #(.DATA_W(DATA_W), .DEPTH(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .flush_i    (flush),
    .count_o    (count),
    .stall_cnt_o(stall_cnt)
  );

  inst_pipe_fifo #(.DATA_W(DATA_W), .DEPTH(3)) dut3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid3),
    .in_data_i  (in_data3),
    .in_ready_o (in_ready3),
    .out_valid_o(out_valid3),
    .out_data_o (out_data3),
    .out_ready_i(out_ready3),
    .flush_i    (flush3),
    .count_o    (count3),
    .stall_cnt_o(stall_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spread an 8-bit tag over both ends of the word to catch high-bit faults.
  function automatic logic [DATA_W-1:0] tag(input logic [7:0] d);
    return {d, 63'h0, d};
  endfunction

  function automatic logic [DATA_W-1:0] sword(input int k);
    return {15'(k), 32'(k * 32'h9E3779B1), 32'(~k)};
  endfunction

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       ev;   // expected out_valid before this row's edge
    logic [7:0] ed;   // expected out_data tag (0 means all-zero word)
    logic [1:0] ec;   // expected count
    logic       er;   // expected in_ready
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  logic [DATA_W-1:0] q3 [$];

  initial begin
    //            iv  d      ordy fl   ev  ed     ec    er
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1}; // push into empty
    tbl[2]  = '{1'b1, 8'h2B, 1'b0, 1'b0, 1'b1, 8'h1A, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h1A, 2'd2, 1'b0}; // full, 3C held off
    tbl[4]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h1A, 2'd2, 1'b0}; // full+pop: no push
    tbl[5]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h2B, 2'd1, 1'b1}; // push+pop
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2, 1'b0}; // flush full + push
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1, 1'b1}; // flush beats push+pop
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1}; // flush while empty
    tbl[16] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    in_valid3  = 1'b0;
    in_data3   = '0;
    out_ready3 = 1'b0;
    flush3     = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid",  80'(out_valid), 80'(1'b0));
    check("rst_data",   80'(out_data),  80'(0));
    check("rst_count",  80'(count),     80'(0));
    check("rst_ready",  80'(in_ready),  80'(1'b1));
    check("rst_stall",  80'(stall_cnt), 80'(0));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tag(tbl[i].d), tbl[i].ordy, tbl[i].fl);
      #1;
      check($sformatf("vec%0d_valid", i), 80'(out_valid), 80'(tbl[i].ev));
      check($sformatf("vec%0d_data", i),  80'(out_data),
            80'(tbl[i].ev ? tag(tbl[i].ed) : '0));
      check($sformatf("vec%0d_count", i), 80'(count),     80'(tbl[i].ec));
      check($sformatf("vec%0d_ready", i), 80'(in_ready),  80'(tbl[i].er));
    end

    // ---------------- async reset mid-run with count=2 ----------------
    @(negedge clk); drive(1'b1, tag(8'hA1), 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, tag(8'hB2), 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("pre_rst_count", 80'(count), 80'(2));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 80'(out_valid), 80'(1'b0));
    check("arst_data",  80'(out_data),  80'(0));
    check("arst_count", 80'(count),     80'(0));
    check("arst_ready", 80'(in_ready),  80'(1'b1));
    check("arst_stall", 80'(stall_cnt), 80'(0));
    @(negedge clk);
    rst = 1'b0;

    // ---------------- stall counter ----------------
    @(negedge clk); drive(1'b1, tag(8'hC3), 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    end
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b1);  // flush with pop
    #1;
    check("stall_5",     80'(stall_cnt), 80'(STALL_EXP));
    check("stall_count", 80'(count),     80'(1));
    check("stall_head",  80'(out_data),  80'(tag(8'hC3)));
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("flush_keeps_stall", 80'(stall_cnt), 80'(STALL_EXP));
    check("post_flush_valid",  80'(out_valid), 80'(1'b0));
    check("post_flush_ready",  80'(in_ready),  80'(1'b1));

    // ---------------- continuous streaming ----------------
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      drive(i < 100, sword(i), 1'b1, 1'b0);
      #1;
      if (i == 0) begin
        check("stream_fill_valid", 80'(out_valid), 80'(1'b0));
      end else begin
        check($sformatf("stream%0d_valid", i), 80'(out_valid), 80'(1'b1));
        check($sformatf("stream%0d_data", i),  80'(out_data),  80'(sword(i - 1)));
        check($sformatf("stream%0d_count", i), 80'(count),     80'(1));
      end
    end
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("stream_drained", 80'(count), 80'(0));

    // ---------------- DEPTH=3 wrap with random backpressure ----------------
    begin
      int pushed  = 0;
      int popped  = 0;
      int cycles  = 0;
      bit push_ok;
      bit pop_ok;
      while ((pushed < 10 || q3.size() != 0) && cycles < 200) begin
        @(negedge clk);
        in_valid3  = (pushed < 10);
        in_data3   = sword(1000 + pushed);
        out_ready3 = 1'($urandom_range(0, 1));
        #1;
        check("d3_valid", 80'(out_valid3), 80'(q3.size() != 0));
        check("d3_count", 80'(count3),     80'(q3.size()));
        check("d3_ready", 80'(in_ready3),  80'(q3.size() != 3));
        if (q3.size() != 0) check("d3_data", 80'(out_data3), 80'(q3[0]));
        push_ok = in_valid3 && (q3.size() != 3);
        pop_ok  = (q3.size() != 0) && out_ready3;
        if (pop_ok) begin
          void'(q3.pop_front());
          popped++;
        end
        if (push_ok) begin
          q3.push_back(in_data3);
          pushed++;
        end
        cycles++;
      end
      check("d3_timeout", 80'(cycles < 200), 80'(1'b1));
      check("d3_popped",  80'(popped),       80'(10));
      @(negedge clk);
      in_valid3  = 1'b0;
      out_ready3 = 1'b0;
      #1;
      check("d3_empty_data", 80'(out_data3), 80'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
